// File: rtl/mem_port_arbiter.sv
// Purpose: round-robin sequencer sharing a dual-port byte RAM between the CPU (0) and copy engine (1), plus F010/FFFE I/O decode.
// Latency: gnt one cycle after req; writes occupy 2 cycles, reads return rdata/rvalid 3 cycles after req.
// Backpressure: a requester holds req and qualifiers until its gnt; one access in flight, the other requester waits.
//
// Ports:
//   clk, reset (async, active-low)
//   req/we/addr/wdata 0|1 : word request, wdata[15:8] -> addr, wdata[7:0] -> addr+1
//   gnt 0|1, rvalid 0|1   : one-cycle pulses to the winning requester
//   rdata                 : registered read data shared by both requesters
//   busy                  : an access is in progress
//   mem_*                 : dual-port RAM drive (port A high byte, port B low byte), mem_q = {q_a, q_b}
//   io_in / io_out        : input port read at IN_ADDR, registered output port written at OUT_ADDR
module mem_port_arbiter #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] OUT_ADDR   = 'hF010,
  parameter logic [ADDR_WIDTH-1:0] IN_ADDR    = 'hFFFE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0,
  input  logic                    req1,
  input  logic                    we0,
  input  logic                    we1,
  input  logic [ADDR_WIDTH-1:0]   addr0,
  input  logic [ADDR_WIDTH-1:0]   addr1,
  input  logic [2*DATA_WIDTH-1:0] wdata0,
  input  logic [2*DATA_WIDTH-1:0] wdata1,
  output logic                    gnt0,
  output logic                    gnt1,
  output logic                    rvalid0,
  output logic                    rvalid1,
  output logic [2*DATA_WIDTH-1:0] rdata,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   mem_addr_a,
  output logic [ADDR_WIDTH-1:0]   mem_addr_b,
  output logic [DATA_WIDTH-1:0]   mem_data_a,
  output logic [DATA_WIDTH-1:0]   mem_data_b,
  output logic                    mem_we_a,
  output logic                    mem_we_b,
  input  logic [2*DATA_WIDTH-1:0] mem_q,
  input  logic [2*DATA_WIDTH-1:0] io_in,
  output logic [2*DATA_WIDTH-1:0] io_out
);

  localparam int WW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic                  last, last_nxt;
  logic                  cur_id, cur_id_nxt;
  logic                  cur_we, cur_we_nxt;
  logic [ADDR_WIDTH-1:0] cur_addr, cur_addr_nxt;
  logic [WW-1:0]         cur_wdata, cur_wdata_nxt;
  logic [1:0]            gnt_q, gnt_nxt;
  logic [1:0]            rvalid_q, rvalid_nxt;
  logic                  we_q, we_nxt;
  logic [ADDR_WIDTH-1:0] addr_a_nxt, addr_b_nxt;
  logic [DATA_WIDTH-1:0] data_a_nxt, data_b_nxt;
  logic [WW-1:0]         rdata_nxt, io_out_nxt;

  logic                  win;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [WW-1:0]         win_wdata;

  always_comb begin
    // On a tie the requester that did not win last time goes first.
    win       = (req0 && req1) ? ~last : req1;
    win_we    = win ? we1    : we0;
    win_addr  = win ? addr1  : addr0;
    win_wdata = win ? wdata1 : wdata0;

    state_nxt     = state;
    last_nxt      = last;
    cur_id_nxt    = cur_id;
    cur_we_nxt    = cur_we;
    cur_addr_nxt  = cur_addr;
    cur_wdata_nxt = cur_wdata;
    gnt_nxt       = 2'b00;
    rvalid_nxt    = 2'b00;
    we_nxt        = 1'b0;
    addr_a_nxt    = '0;
    addr_b_nxt    = '0;
    data_a_nxt    = '0;
    data_b_nxt    = '0;
    rdata_nxt     = rdata;
    io_out_nxt    = io_out;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nxt     = ACCESS;
          last_nxt      = win;
          cur_id_nxt    = win;
          cur_we_nxt    = win_we;
          cur_addr_nxt  = win_addr;
          cur_wdata_nxt = win_wdata;
          // Memory drive is registered here so it is stable for the whole ACCESS cycle.
          gnt_nxt       = win ? 2'b10 : 2'b01;
          we_nxt        = win_we;
          addr_a_nxt    = win_addr;
          addr_b_nxt    = win_addr + ADDR_WIDTH'(1);  // wraps 0xFFFF -> 0x0000
          data_a_nxt    = win_wdata[WW-1:DATA_WIDTH];
          data_b_nxt    = win_wdata[DATA_WIDTH-1:0];
        end
      end
      ACCESS: begin
        if (cur_we) begin
          state_nxt = IDLE;
          // The RAM is written as well; the output port only shadows it.
          if (cur_addr == OUT_ADDR) io_out_nxt = cur_wdata;
        end else begin
          state_nxt = RDWAIT;
        end
      end
      RDWAIT: begin
        rdata_nxt  = (cur_addr == IN_ADDR) ? io_in : mem_q;
        rvalid_nxt = cur_id ? 2'b10 : 2'b01;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last       <= 1'b1;  // CPU wins the first tie
      cur_id     <= 1'b0;
      cur_we     <= 1'b0;
      cur_addr   <= '0;
      cur_wdata  <= '0;
      gnt_q      <= 2'b00;
      rvalid_q   <= 2'b00;
      we_q       <= 1'b0;
      mem_addr_a <= '0;
      mem_addr_b <= '0;
      mem_data_a <= '0;
      mem_data_b <= '0;
      rdata      <= '0;
      io_out     <= '0;
    end else begin
      state      <= state_nxt;
      last       <= last_nxt;
      cur_id     <= cur_id_nxt;
      cur_we     <= cur_we_nxt;
      cur_addr   <= cur_addr_nxt;
      cur_wdata  <= cur_wdata_nxt;
      gnt_q      <= gnt_nxt;
      rvalid_q   <= rvalid_nxt;
      we_q       <= we_nxt;
      mem_addr_a <= addr_a_nxt;
      mem_addr_b <= addr_b_nxt;
      mem_data_a <= data_a_nxt;
      mem_data_b <= data_b_nxt;
      rdata      <= rdata_nxt;
      io_out     <= io_out_nxt;
    end
  end

  assign gnt0     = gnt_q[0];
  assign gnt1     = gnt_q[1];
  assign rvalid0  = rvalid_q[0];
  assign rvalid1  = rvalid_q[1];
  assign mem_we_a = we_q;
  assign mem_we_b = we_q;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: randomized + directed bench for mem_port_arbiter against a transaction-level model.
// Latency: model predicts grant cycles, rvalid cycles, read data and io_out from the access rules.
// Backpressure: each requester holds its request until granted; waits are bounded.
module tb_mem_port_arbiter;

  localparam logic [15:0] OUT_A = 16'hF010;
  localparam logic [15:0] IN_A  = 16'hFFFE;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [15:0] rdata;
  logic [15:0] mem_addr_a, mem_addr_b;
  logic [7:0]  mem_data_a, mem_data_b;
  logic        mem_we_a, mem_we_b;
  logic [15:0] mem_q, io_in, io_out;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy),
    .mem_addr_a(mem_addr_a), .mem_addr_b(mem_addr_b),
    .mem_data_a(mem_data_a), .mem_data_b(mem_data_b),
    .mem_we_a(mem_we_a), .mem_we_b(mem_we_b),
    .mem_q(mem_q), .io_in(io_in), .io_out(io_out)
  );

  // Environment RAM: writes committed by the main process, synchronous read here.
  logic [7:0] ram [0:65535];
  logic [7:0] q_a, q_b;
  always @(posedge clk) begin
    q_a <= ram[mem_addr_a];
    q_b <= ram[mem_addr_b];
  end
  assign mem_q = {q_a, q_b};

  logic [86:0] all_outs;
  assign all_outs = {gnt0, gnt1, rvalid0, rvalid1, rdata, busy, mem_addr_a, mem_addr_b,
                     mem_data_a, mem_data_b, mem_we_a, mem_we_b, io_out};

  // Reference model state
  logic [7:0]  ref_mem [0:65535];
  logic [15:0] io_hist [0:8191];
  txn_t        q0[$], q1[$];
  txn_t        cur [2];
  logic        act [2];
  int          waitc [2];
  logic [1:0]  prev_req;
  logic        last_w;
  int          cyc, free_at, rv_at, io_pend_at, gnt_cnt;
  logic        rv_id;
  logic [15:0] rv_addr, io_pend_val, exp_io_out;
  logic        io_fix_en;
  logic [15:0] io_fix;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] init_byte(input int a);
    return 8'(a) ^ 8'(a >> 8) ^ 8'h5C;
  endfunction

  function automatic txn_t mk(input logic we, input logic [15:0] a, input logic [15:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    logic [15:0] a;
    case ($urandom % 8)
      0: a = OUT_A;
      1: a = IN_A;
      2: a = 16'hFFFF;
      3: a = 16'h0010;
      default: a = 16'($urandom % 64);
    endcase
    return mk(1'($urandom % 2), a, 16'($urandom));
  endfunction

  function automatic void model_reset();
    last_w = 1'b1; free_at = 0; rv_at = -1; io_pend_at = -1; exp_io_out = 16'h0;
    act[0] = 1'b0; act[1] = 1'b0; waitc[0] = 0; waitc[1] = 0;
    q0.delete(); q1.delete(); prev_req = 2'b00;
  endfunction

  // One cycle: observe at the falling edge, check, then drive the next inputs.
  task automatic step();
    logic [1:0]  exp_g, exp_rv;
    logic        w;
    txn_t        t;
    logic [15:0] a1, exp_rd;
    @(negedge clk);
    cyc++;
    if (mem_we_a) ram[mem_addr_a] = mem_data_a;
    if (mem_we_b) ram[mem_addr_b] = mem_data_b;

    if (cyc == io_pend_at) exp_io_out = io_pend_val;
    check("io_out", io_out, exp_io_out);

    exp_g = 2'b00;
    w = 1'b0;
    if (cyc >= free_at && prev_req != 2'b00) begin
      w = (prev_req == 2'b11) ? ~last_w : prev_req[1];
      exp_g = w ? 2'b10 : 2'b01;
    end
    check("gnt", {gnt1, gnt0}, exp_g);
    if (exp_g != 2'b00) begin
      t  = cur[w];
      a1 = t.addr + 16'd1;
      check("mem_addr_a", mem_addr_a, t.addr);
      check("mem_addr_b", mem_addr_b, a1);
      check("mem_data", {mem_data_a, mem_data_b}, t.wdata);
      check("mem_we", {mem_we_a, mem_we_b}, {t.we, t.we});
      last_w = w; act[w] = 1'b0; waitc[w] = 0; gnt_cnt++;
      if (t.we) begin
        ref_mem[t.addr] = t.wdata[15:8];
        ref_mem[a1]     = t.wdata[7:0];
        if (t.addr == OUT_A) begin io_pend_at = cyc + 1; io_pend_val = t.wdata; end
        free_at = cyc + 2;
      end else begin
        rv_at = cyc + 2; rv_id = w; rv_addr = t.addr; free_at = cyc + 3;
      end
    end else begin
      check("mem_idle", {mem_we_a, mem_we_b, mem_addr_a, mem_addr_b, mem_data_a, mem_data_b}, '0);
    end
    check("busy", busy, (cyc + 1 < free_at));

    exp_rv = (cyc == rv_at) ? (rv_id ? 2'b10 : 2'b01) : 2'b00;
    check("rvalid", {rvalid1, rvalid0}, exp_rv);
    if (cyc == rv_at) begin
      a1 = rv_addr + 16'd1;
      exp_rd = (rv_addr == IN_A) ? io_hist[(cyc - 1) % 8192] : {ref_mem[rv_addr], ref_mem[a1]};
      check("rdata", rdata, exp_rd);
    end

    for (int r = 0; r < 2; r++) begin
      if (act[r]) begin
        waitc[r]++;
        if (waitc[r] > 8) begin
          check("wait_bound", waitc[r], 8);
          act[r] = 1'b0;
        end
      end
    end

    if (!act[0] && q0.size() != 0) begin cur[0] = q0.pop_front(); act[0] = 1'b1; waitc[0] = 0; end
    if (!act[1] && q1.size() != 0) begin cur[1] = q1.pop_front(); act[1] = 1'b1; waitc[1] = 0; end
    req0 = act[0]; we0 = cur[0].we; addr0 = cur[0].addr; wdata0 = cur[0].wdata;
    req1 = act[1]; we1 = cur[1].we; addr1 = cur[1].addr; wdata1 = cur[1].wdata;
    io_in = io_fix_en ? io_fix : 16'($urandom);
    io_hist[cyc % 8192] = io_in;
    prev_req = {req1, req0};
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || act[0] || act[1] ||
            cyc < free_at || cyc <= rv_at || cyc < io_pend_at) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check("drain_timeout", n, 0);
    step();
  endtask

  initial begin
    int n, g0;
    for (int i = 0; i < 65536; i++) begin
      ram[i] = init_byte(i);
      ref_mem[i] = init_byte(i);
    end
    cyc = 0; gnt_cnt = 0; io_fix_en = 1'b0; io_fix = 16'h0;
    cur[0] = '0; cur[1] = '0;
    rv_id = 1'b0; rv_addr = 16'h0; io_pend_val = 16'h0;
    model_reset();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 16'h0; addr1 = 16'h0; wdata0 = 16'h0; wdata1 = 16'h0; io_in = 16'h0;

    #2 reset = 1'b0;
    #1 check("reset_outs", all_outs, '0);
    step(); step();
    reset = 1'b1;
    step();

    // Both requesters streaming reads: tie order starts with the CPU.
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'b0, 16'(16'h0100 + 2 * i), 16'h0));
      q1.push_back(mk(1'b0, 16'(16'h0200 + 2 * i), 16'h0));
    end
    drain(60);

    // Write then read back a word.
    q0.push_back(mk(1'b1, 16'h0010, 16'hA55A));
    drain(20);
    q0.push_back(mk(1'b0, 16'h0010, 16'h0));
    drain(20);

    // Output port write (memory also written) and input port read.
    q0.push_back(mk(1'b1, OUT_A, 16'h1234));
    drain(20);
    q0.push_back(mk(1'b0, OUT_A, 16'h0));
    io_fix_en = 1'b1; io_fix = 16'hBEEF;
    q1.push_back(mk(1'b0, IN_A, 16'h0));
    drain(30);
    io_fix_en = 1'b0;

    // Address wrap at the top of memory.
    q1.push_back(mk(1'b1, 16'hFFFF, 16'hC3D4));
    q1.push_back(mk(1'b0, 16'hFFFF, 16'h0));
    q0.push_back(mk(1'b0, 16'h0000, 16'h0));
    drain(40);

    // Random traffic from both requesters.
    for (int i = 0; i < 1200; i++) begin
      if (q0.size() == 0 && ($urandom % 3) != 0) q0.push_back(rand_txn());
      if (q1.size() == 0 && ($urandom % 3) != 0) q1.push_back(rand_txn());
      step();
    end
    drain(100);

    // Make io_out non-zero, then reset during the RDWAIT cycle of a read.
    q0.push_back(mk(1'b1, OUT_A, 16'h5A5A));
    drain(20);
    q0.push_back(mk(1'b0, 16'h0020, 16'h0));
    n = 0; g0 = gnt_cnt;
    while (gnt_cnt == g0 && n < 20) begin step(); n++; end
    if (gnt_cnt == g0) check("rst_gnt_timeout", n, 0);
    step();
    reset = 1'b0;
    #1 check("reset_mid_rdwait", all_outs, '0);
    model_reset();
    req0 = 1'b0; req1 = 1'b0;
    step(); step();
    reset = 1'b1;
    step(); step(); step();
    q0.push_back(mk(1'b1, 16'h0030, 16'h1111));
    q1.push_back(mk(1'b1, 16'h0040, 16'h2222));
    drain(30);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencing arbiter sharing the dual-port byte memory between two 16-bit word requesters: requester 0 is the CPU, requester 1 is the block-copy engine. Each granted word access drives both byte ports, with port A on the high byte at addr and port B on the low byte at addr+1. The block also owns the memory-mapped I/O decode: the registered output port at 0xF010 and the input port at 0xFFFE. It sits between the core/copy engine and `memory`, and replaces the combinational I/O muxing in front of it.

## Interface
- DATA_WIDTH, 8, byte width of each memory port
- ADDR_WIDTH, 16, address width
- OUT_ADDR, 'hF010, write address latched into io_out
- IN_ADDR, 'hFFFE, read address that returns io_in

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- req0 / req1  in  1  access request; held with its qualifiers until the matching gnt
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_WIDTH  word byte-address
- wdata0 / wdata1  in  2*DATA_WIDTH  write data, bits [15:8] to addr, bits [7:0] to addr+1
- gnt0 / gnt1  out  1  one-cycle pulse; the access is being performed this cycle
- rvalid0 / rvalid1  out  1  one-cycle pulse; rdata is valid for that requester
- rdata  out  2*DATA_WIDTH  registered read data, shared between requesters
- busy  out  1  state != IDLE
- mem_addr_a, mem_addr_b  out  ADDR_WIDTH  memory port addresses
- mem_data_a, mem_data_b  out  DATA_WIDTH  memory write bytes
- mem_we_a, mem_we_b  out  1  memory write enables
- mem_q  in  2*DATA_WIDTH  {q_a, q_b}; synchronous RAM, valid one cycle after address
- io_in  in  16  external input port
- io_out  out  16  registered external output port

## Operation
- The FSM has three states: IDLE, ACCESS, RDWAIT.
- IDLE:
  - If any req is asserted, select a winner and latch its we/addr/wdata and its id, then go to ACCESS.
  - With no request, stay in IDLE.
- Arbitration is round-robin over the last winner (`last`).
  - If only one req is asserted, that requester wins.
  - If both are asserted, the requester other than `last` wins.
  - `last` updates on every grant.
- ACCESS (exactly one cycle):
  - Drive mem_addr_a = addr and mem_addr_b = addr+1. The increment is modulo 2^ADDR_WIDTH, so 0xFFFF pairs with 0x0000.
  - Drive mem_data_a = wdata[15:8] and mem_data_b = wdata[7:0].
  - mem_we_a = mem_we_b = we.
  - Pulse gnt of the winner.
  - On a write, go to IDLE. If addr == OUT_ADDR, also load io_out <= wdata on this edge; the memory is still written.
  - On a read, go to RDWAIT.
- RDWAIT (one cycle):
  - Capture rdata <= (addr == IN_ADDR) ? io_in : mem_q.
  - Pulse rvalid of the winner on the following cycle, concurrently with the return to IDLE.
- Outside ACCESS, all mem_* outputs are 0 and both write enables are deasserted.
- A requester may deassert req after gnt. A req still asserted after gnt is treated as a new request.
- Reset (asynchronous, at any time, including mid-ACCESS or mid-RDWAIT):
  - state = IDLE, last = 1 (so the CPU wins the first tie).
  - gnt*, rvalid*, busy, mem_we_* = 0; mem_addr/data = 0; rdata = 0; io_out = 0.
  - Any in-flight access is dropped: no gnt or rvalid is issued for it.

## Timing
- Write: req seen at edge T0, gnt at T1 (memory written at the T1 edge), IDLE at T2. Back-to-back writes complete every 2 cycles.
- Read: req at T0, gnt at T1, mem_q valid in cycle T2 (RDWAIT), rdata/rvalid at T3. Back-to-back reads complete every 3 cycles.
- rvalid coincides with IDLE, so a new grant is decided in the same cycle as rvalid.
- All outputs are registered. There is no combinational path from req to gnt.
- io_in is sampled once, on the RDWAIT edge. A change after that edge does not alter rdata.

## Test plan
- Reset release, single CPU write {addr0=0x0010, wdata0=0xA55A} → gnt0 one cycle later, with mem_addr_a=0x0010, mem_addr_b=0x0011, data 0xA5/0x5A and both we high for exactly one cycle. A subsequent read of 0x0010 → rvalid0 with rdata=0xA55A, 3 cycles after req.
- req0 and req1 held continuously, both reads → grants alternate 0,1,0,1 starting with 0. rvalid goes to the matching requester each time, and req1 never waits more than one foreign access.
- Write 0x1234 to 0xF010 → io_out=0x1234 on the cycle after gnt, and memory at 0xF010/0xF011 also holds 0x12/0x34. A read of 0xFFFE with io_in=0xBEEF → rdata=0xBEEF, not memory contents.
- Access at 0xFFFF → mem_addr_a=0xFFFF, mem_addr_b=0x0000.
- reset asserted in the RDWAIT cycle of a read → all outputs 0 immediately. No rvalid is issued after release, io_out=0, and the first tie after release is granted to requester 0.
